// File: rtl/serial_link_pkg.sv
// Shared types and defaults for the 4-bit MSB-first serial link.
package serial_link_pkg;

    typedef enum logic [1:0] {IDLE, SHIFT, PARITY} rx_state_t;

    localparam int DEFAULT_WIDTH = 4;

endpackage

// File: rtl/serial_to_parallel_rx_holding_reg.sv
// Single-entry valid/ready output buffer; drops a new word and pulses overrun when full.
module output_holding_reg #(
    parameter int DW = 4
) (
    input  logic          clk,
    input  logic          reset_n,
    input  logic          load_i,
    input  logic [DW-1:0] word_i,
    input  logic          ready_i,
    output logic [DW-1:0] data_o,
    output logic          valid_o,
    output logic          overrun_o
);

    logic [DW-1:0] data_q;
    logic          valid_q;
    logic          overrun_q;
    logic          take_d;

    // A new word fits if the slot is empty or is being drained on this edge.
    assign take_d = load_i && (!valid_q || ready_i);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            data_q    <= '0;
            valid_q   <= 1'b0;
            overrun_q <= 1'b0;
        end else begin
            overrun_q <= load_i && !take_d;
            if (take_d) begin
                data_q  <= word_i;
                valid_q <= 1'b1;
            end else if (valid_q && ready_i) begin
                valid_q <= 1'b0;
            end
        end
    end

    assign data_o    = data_q;
    assign valid_o   = valid_q;
    assign overrun_o = overrun_q;

endmodule

// File: rtl/serial_to_parallel_rx.sv
// Serial-to-parallel receiver: MSB-first framed bits into a buffered valid/ready word port.
// Optional trailing even-parity bit and parity_error output when PARITY_CHECK_EN is defined.
module serial_to_parallel_rx
    import serial_link_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             serial_in,
    input  logic             serial_valid,
    input  logic             frame_start,
    output logic [WIDTH-1:0] parallel_data_out,
    output logic             data_valid,
    input  logic             data_ready,
    output logic             overrun,
`ifdef PARITY_CHECK_EN
    output logic             parity_error,
`endif
    output logic             busy
);

    localparam int CW = $clog2(WIDTH + 1);
`ifdef PARITY_CHECK_EN
    localparam int SW = WIDTH;
    localparam int DW = WIDTH + 1;
`else
    // The final data bit goes straight to the holding register, so only WIDTH-1 are kept.
    localparam int SW = WIDTH - 1;
    localparam int DW = WIDTH;
`endif

    rx_state_t     state_q;
    logic [CW-1:0] bit_cnt_q;
    logic [SW-1:0] shreg_q;
    logic [SW-1:0] shreg_d;
    logic          last_bit;
    logic          word_done;
    logic [DW-1:0] word_d;
    logic [DW-1:0] hold_data;

    assign shreg_d  = SW'({shreg_q, serial_in});
    assign last_bit = (bit_cnt_q == CW'(WIDTH - 1));

`ifdef PARITY_CHECK_EN
    assign word_done = serial_valid && !frame_start && (state_q == PARITY);
    assign word_d    = {serial_in ^ (^shreg_q), shreg_q};
`else
    assign word_done = serial_valid && !frame_start && (state_q == SHIFT) && last_bit;
    assign word_d    = {shreg_q, serial_in};
`endif

    // frame_start wins in every state, so a partial word is abandoned without trace.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q   <= IDLE;
            bit_cnt_q <= '0;
            shreg_q   <= '0;
        end else if (serial_valid) begin
            if (frame_start) begin
                shreg_q   <= shreg_d;
                bit_cnt_q <= CW'(1);
                state_q   <= SHIFT;
            end else begin
                case (state_q)
                    SHIFT: begin
                        shreg_q   <= shreg_d;
                        bit_cnt_q <= bit_cnt_q + CW'(1);
                        if (last_bit) begin
`ifdef PARITY_CHECK_EN
                            state_q <= PARITY;
`else
                            state_q <= IDLE;
`endif
                        end
                    end
`ifdef PARITY_CHECK_EN
                    PARITY: state_q <= IDLE;
`endif
                    default: ;
                endcase
            end
        end
    end

    output_holding_reg #(.DW(DW)) u_hold (
        .clk      (clk),
        .reset_n  (reset_n),
        .load_i   (word_done),
        .word_i   (word_d),
        .ready_i  (data_ready),
        .data_o   (hold_data),
        .valid_o  (data_valid),
        .overrun_o(overrun)
    );

    assign parallel_data_out = hold_data[WIDTH-1:0];
`ifdef PARITY_CHECK_EN
    assign parity_error = data_valid && hold_data[WIDTH];
`endif
    assign busy = (state_q != IDLE);

endmodule
